// File: rtl/data_mem.sv
// data_mem: data-side memory responder for the single-cycle MIPS32 core.
//
// Word-addressed RAM sits behind a one-entry posted store buffer. A RAM store
// is captured in the buffer on the edge that samples it and is written into
// the array on the following edge. Loads are combinational and forward from
// the buffer when it holds the addressed word.
//
// Optional MMIO window, present only when the macro DMEM_MMIO_EN is defined:
//   0xFFFF_0000 CYCLE  (read-only, free-running cycle counter)
//   0xFFFF_0004 STORES (read-only, count of accepted RAM stores)
//   0xFFFF_0008 IO_OUT (read/write, drives io_out)
// Without the macro every 0xFFFF_xxxx access is unmapped and io_out is 0.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-low reset
//   load_en   load request this cycle
//   l_addr    load byte address
//   l_data    load result (combinational, 0 when load_en is low)
//   store_en  store request this cycle
//   s_addr    store byte address
//   s_data    store data (full word)
//   io_out    IO_OUT register contents
//   err       sticky flag for misaligned/unmapped accesses
module data_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] l_addr,
  output logic [W-1:0] l_data,
  input  logic         store_en,
  input  logic [W-1:0] s_addr,
  input  logic [W-1:0] s_data,
  output logic [W-1:0] io_out,
  output logic         err
);

  localparam int           AW         = $clog2(DEPTH);
  localparam logic [W-1:0] RAM_BYTES  = W'(DEPTH * 4);
  localparam logic [15:0]  OFF_CYCLE  = 16'h0000;
  localparam logic [15:0]  OFF_STORES = 16'h0004;
  localparam logic [15:0]  OFF_IO     = 16'h0008;

  logic [W-1:0]  mem [DEPTH];

  logic          buf_valid;
  logic [AW-1:0] buf_idx;
  logic [W-1:0]  buf_data;

  logic          l_ram;
  logic          l_mmio;
  logic          s_ram;
  logic          s_mmio;
  logic [AW-1:0] l_idx;
  logic [AW-1:0] s_idx;
  logic          ram_store;
  logic          load_fault;
  logic          store_fault;

  assign l_idx = l_addr[AW+1:2];
  assign s_idx = s_addr[AW+1:2];
  assign l_ram = (l_addr[1:0] == 2'b00) && (l_addr < RAM_BYTES);
  assign s_ram = (s_addr[1:0] == 2'b00) && (s_addr < RAM_BYTES);

`ifdef DMEM_MMIO_EN
  logic [W-1:0] cycle_cnt;
  logic [W-1:0] store_cnt;
  logic [W-1:0] io_reg;

  // Only the three defined registers count as mapped; other offsets fault.
  assign l_mmio = (l_addr[1:0] == 2'b00) && (l_addr[31:16] == 16'hFFFF) &&
                  ((l_addr[15:0] == OFF_CYCLE) || (l_addr[15:0] == OFF_STORES) ||
                   (l_addr[15:0] == OFF_IO));
  assign s_mmio = (s_addr[1:0] == 2'b00) && (s_addr[31:16] == 16'hFFFF) &&
                  ((s_addr[15:0] == OFF_CYCLE) || (s_addr[15:0] == OFF_STORES) ||
                   (s_addr[15:0] == OFF_IO));
  assign io_out = io_reg;
`else
  assign l_mmio = 1'b0;
  assign s_mmio = 1'b0;
  assign io_out = '0;
`endif

  assign ram_store   = store_en && s_ram;
  assign load_fault  = load_en && !l_ram && !l_mmio;
  assign store_fault = store_en && !s_ram && !s_mmio;

  // Load mux. Registers are read before this cycle's edge, so a same-cycle
  // store to the same location is never visible to the load.
  always_comb begin
    l_data = '0;
    if (load_en) begin
      if (l_ram) begin
        l_data = (buf_valid && (buf_idx == l_idx)) ? buf_data : mem[l_idx];
      end
`ifdef DMEM_MMIO_EN
      else if (l_mmio) begin
        case (l_addr[15:0])
          OFF_CYCLE:  l_data = cycle_cnt;
          OFF_STORES: l_data = store_cnt;
          OFF_IO:     l_data = io_reg;
          default:    l_data = '0;
        endcase
      end
`endif
    end
  end

  // Store buffer and sticky error flag. The buffer drains and refills on the
  // same edge; with no new RAM store it simply empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
      err       <= 1'b0;
    end else begin
      buf_valid <= ram_store;
      if (ram_store) begin
        buf_idx  <= s_idx;
        buf_data <= s_data;
      end
      err <= err | load_fault | store_fault;
    end
  end

  // Array write from the buffer. The array itself has no reset; a reset
  // clears buf_valid, which discards any store still waiting here.
  always_ff @(posedge clk) begin
    if (buf_valid) begin
      mem[buf_idx] <= buf_data;
    end
  end

`ifdef DMEM_MMIO_EN
  // MMIO registers. Stores to CYCLE/STORES are mapped but have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      store_cnt <= '0;
      io_reg    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (ram_store) begin
        store_cnt <= store_cnt + 1'b1;
      end
      if (store_en && s_mmio && (s_addr[15:0] == OFF_IO)) begin
        io_reg <= s_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem.
// The reference model treats memory as an associative array of words that a
// store updates at the sampling edge; the store buffer is invisible at this
// level except when a reset discards the most recent store.
module tb_data_mem;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         load_en;
  logic [31:0]  l_addr;
  logic [31:0]  l_data;
  logic         store_en;
  logic [31:0]  s_addr;
  logic [31:0]  s_data;
  logic [31:0]  io_out;
  logic         err;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] cyc_m;
  logic [31:0] stores_m;
  logic [31:0] io_m;
  logic        err_m;

  data_mem #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .l_addr   (l_addr),
    .l_data   (l_data),
    .store_en (store_en),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .io_out   (io_out),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 0 = RAM, 1 = MMIO register, 2 = fault
  function automatic int kind_of(logic [31:0] a);
    if (a[1:0] != 2'b00) return 2;
    if (a < 32'(DEPTH * 4)) return 0;
    if (MMIO_EN && a[31:16] == 16'hFFFF &&
        (a[15:0] == 16'h0 || a[15:0] == 16'h4 || a[15:0] == 16'h8)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] model_load(logic en, logic [31:0] a);
    int k;
    if (!en) return 32'h0;
    k = kind_of(a);
    if (k == 0) begin
      if (ram_m.exists(int'(a >> 2))) return ram_m[int'(a >> 2)];
      return 32'h0;
    end
    if (k == 1) begin
      if (a[15:0] == 16'h0) return cyc_m;
      if (a[15:0] == 16'h4) return stores_m;
      return io_m;
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    cyc_m    = 0;
    stores_m = 0;
    io_m     = 0;
    err_m    = 0;
  endtask

  // Apply the effect of one clock edge using the inputs currently driven.
  task automatic model_commit();
    int k;
    cyc_m = cyc_m + 1;
    if (load_en && kind_of(l_addr) == 2) err_m = 1'b1;
    if (store_en) begin
      k = kind_of(s_addr);
      if (k == 0) begin
        ram_m[int'(s_addr >> 2)] = s_data;
        stores_m = stores_m + 1;
      end else if (k == 1) begin
        if (s_addr[15:0] == 16'h8) io_m = s_data;
      end else begin
        err_m = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic le, input logic [31:0] la,
                       input logic se, input logic [31:0] sa, input logic [31:0] sd);
    load_en  = le;
    l_addr   = la;
    store_en = se;
    s_addr   = sa;
    s_data   = sd;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'($urandom_range(0, 15) * 4);
    if (r <= 7) return 32'hFFFF_0000 + 32'($urandom_range(0, 2) * 4);
    if (r == 8) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    case ($urandom_range(0, 2))
      0:       return 32'h0000_1000 + 32'($urandom_range(0, 15) * 4);
      1:       return 32'hFFFF_000C;
      default: return 32'h8000_0000;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] exp;
    rst = 1'b0;
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #3;
    if (io_out !== 32'h0) begin
      n_mismatched++; $display("[TB] FAIL reset_io_out: got %h want %h", io_out, 32'h0);
    end
    n_compared++;
    if (err !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_err: got %b want 0", err);
    end
    n_compared++;
    if (l_data !== 32'h0) begin
      n_mismatched++; $display("[TB] FAIL reset_l_data_idle: got %h want 0", l_data);
    end
    n_compared++;
    drive(1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 32'h0);
    #1;
    exp = model_load(1'b1, 32'hFFFF_0000);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL reset_cycle_read: got %h want %h", l_data, exp);
    end
    n_compared++;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_store_forward();
    logic [31:0] exp;
    drive(1'b0, 32'h0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    edge_step();
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'h10);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL fwd_load: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    edge_step();
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'h10);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL array_load: got %h want %h", l_data, exp);
    end
    n_compared++;
    if (err !== err_m) begin
      n_mismatched++; $display("[TB] FAIL fwd_err: got %b want %b", err, err_m);
    end
    n_compared++;
    edge_step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h1);
    edge_step();
    drive(1'b0, 32'h0, 1'b1, 32'h4, 32'h2);
    edge_step();
    drive(1'b0, 32'h0, 1'b1, 32'h0, 32'h3);
    edge_step();
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'h0);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL b2b_word0: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'h4);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL b2b_word1: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
    drive(1'b1, 32'hFFFF_0004, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'hFFFF_0004);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL b2b_stores: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
  endtask

  task automatic test_io_same_cycle();
    logic [31:0] exp;
    drive(1'b1, 32'hFFFF_0008, 1'b1, 32'hFFFF_0008, 32'h55);
    #2;
    exp = model_load(1'b1, 32'hFFFF_0008);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL io_same_cycle: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
    drive(1'b1, 32'hFFFF_0008, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'hFFFF_0008);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL io_next_cycle: got %h want %h", l_data, exp);
    end
    n_compared++;
    if (io_out !== io_m) begin
      n_mismatched++; $display("[TB] FAIL io_out_port: got %h want %h", io_out, io_m);
    end
    n_compared++;
    if (err !== err_m) begin
      n_mismatched++; $display("[TB] FAIL io_err: got %b want %b", err, err_m);
    end
    n_compared++;
    edge_step();
  endtask

  task automatic test_errors();
    logic [31:0] exp;
    drive(1'b1, 32'h2, 1'b0, 32'h0, 32'h0);
    #2;
    if (l_data !== 32'h0) begin
      n_mismatched++; $display("[TB] FAIL misaligned_load: got %h want 0", l_data);
    end
    n_compared++;
    edge_step();
    if (err !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL err_set: got %b want 1", err);
    end
    n_compared++;
    drive(1'b0, 32'h0, 1'b1, 32'h0001_0000, 32'h1234_5678);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    edge_step();
    edge_step();
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    #2;
    exp = model_load(1'b1, 32'h0);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL unmapped_store_dropped: got %h want %h", l_data, exp);
    end
    n_compared++;
    if (err !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL err_sticky: got %b want 1", err);
    end
    n_compared++;
    edge_step();
  endtask

  task automatic test_reset_discard();
    logic [31:0] prev;
    logic [31:0] exp;
    drive(1'b0, 32'h0, 1'b1, 32'h20, 32'hAAAA_1111);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    edge_step();
    edge_step();
    prev = ram_m[8];
    drive(1'b0, 32'h0, 1'b1, 32'h20, 32'hBBBB_2222);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    model_reset();
    ram_m[8] = prev;
    #1;
    drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
    #1;
    exp = model_load(1'b1, 32'h20);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL discard_in_reset: got %h want %h", l_data, exp);
    end
    n_compared++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    exp = model_load(1'b1, 32'h20);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL discard_after_reset: got %h want %h", l_data, exp);
    end
    n_compared++;
    edge_step();
  endtask

  task automatic test_cycle_counter();
    logic [31:0] exp;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    edge_step();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 32'h0);
      #2;
      exp = model_load(1'b1, 32'hFFFF_0000);
      if (l_data !== exp) begin
        n_mismatched++; $display("[TB] FAIL cycle_read_%0d: got %h want %h", i, l_data, exp);
      end
      n_compared++;
      edge_step();
    end
    drive(1'b0, 32'h0, 1'b1, 32'hFFFF_0008, 32'hCAFE_0001);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    if (io_out !== io_m) begin
      n_mismatched++; $display("[TB] FAIL midclk_io_out: got %h want %h", io_out, io_m);
    end
    n_compared++;
    if (err !== err_m) begin
      n_mismatched++; $display("[TB] FAIL midclk_err: got %b want %b", err, err_m);
    end
    n_compared++;
    drive(1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 32'h0);
    #1;
    exp = model_load(1'b1, 32'hFFFF_0000);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL midclk_cycle: got %h want %h", l_data, exp);
    end
    n_compared++;
    drive(1'b1, 32'hFFFF_0004, 1'b0, 32'h0, 32'h0);
    #1;
    exp = model_load(1'b1, 32'hFFFF_0004);
    if (l_data !== exp) begin
      n_mismatched++; $display("[TB] FAIL midclk_stores: got %h want %h", l_data, exp);
    end
    n_compared++;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic        le;
    logic        se;
    logic [31:0] la;
    logic [31:0] sa;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'(i * 4), $urandom);
      edge_step();
    end
    for (int i = 0; i < 400; i++) begin
      le = 1'($urandom_range(0, 3) != 0);
      se = 1'($urandom_range(0, 1));
      la = rand_addr();
      sa = rand_addr();
      if ($urandom_range(0, 4) == 0) sa = la;
      drive(le, la, se, sa, $urandom);
      #2;
      exp = model_load(le, la);
      if (l_data !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL rand_load_%0d addr %h: got %h want %h", i, la, l_data, exp);
      end
      n_compared++;
      if (io_out !== io_m) begin
        n_mismatched++; $display("[TB] FAIL rand_io_out_%0d: got %h want %h", i, io_out, io_m);
      end
      n_compared++;
      if (err !== err_m) begin
        n_mismatched++; $display("[TB] FAIL rand_err_%0d: got %b want %b", i, err, err_m);
      end
      n_compared++;
      edge_step();
    end
  endtask

  initial begin
    test_reset();
    test_store_forward();
    test_back_to_back();
    test_io_same_cycle();
    test_errors();
    test_reset_discard();
    test_cycle_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem.md
# data_mem

Data-side memory responder for the MIPS32 core: services the core's `load_en/l_addr/l_data` and `store_en/s_addr/s_data` ports. Word-addressed RAM behind a one-entry posted store buffer with load forwarding, plus a small memory-mapped I/O window (cycle counter, store counter, output register). Loads complete combinationally in the issuing cycle, so the single-cycle core needs no stall; stores are posted and committed one cycle later.

## Interface

- `W`, 32, data/address width (must be 32).
- `DEPTH`, 1024, RAM size in words (power of two); RAM occupies byte addresses `0 .. DEPTH*4-1`.
- `clk` in 1, sole clock; all state updates on rising edge.
- `rst` in 1, reset, asynchronous, active-low.
- `load_en` in 1, load request this cycle.
- `l_addr` in W, load byte address.
- `l_data` out W, load result (combinational).
- `store_en` in 1, store request this cycle.
- `s_addr` in W, store byte address.
- `s_data` in W, store data (full word).
- `io_out` out W, contents of IO_OUT register.
- `err` out 1, sticky access-error flag.

## Operation

- Address decode (per port): misaligned if `addr[1:0]!=0`; RAM if aligned and `addr < DEPTH*4`; MMIO if aligned and `addr[31:16]==16'hFFFF`; otherwise unmapped. RAM word index = `addr[log2(DEPTH)+1:2]`.
- MMIO map: `0xFFFF_0000` CYCLE (RO), `0xFFFF_0004` STORES (RO), `0xFFFF_0008` IO_OUT (RW). Other MMIO offsets are unmapped.
- Store buffer: registers `buf_valid`, `buf_idx`, `buf_data`. Each edge: if `buf_valid`, write `buf_data` into RAM at `buf_idx`. Concurrently, an accepted RAM store loads the buffer (`buf_valid=1`); with no RAM store, `buf_valid` clears. Drain and refill in the same cycle are required.
- Load path: RAM load returns `buf_data` if `buf_valid && buf_idx==load index`, else the array word. MMIO load returns register value. Unmapped or misaligned load returns 0. `l_data=0` when `load_en=0`.
- Same-cycle load and store to the same location: load returns the value prior to this cycle's store (applies to RAM, IO_OUT, STORES).
- CYCLE: increments every cycle out of reset, wraps at 2^32.
- STORES: increments on each accepted RAM store, wraps.
- IO_OUT: written by MMIO store to `0xFFFF_0008`. Stores to RO registers are ignored without error.
- Errors: any enabled load/store that is misaligned or unmapped is dropped (no state change besides `err`) and sets `err`. `err` clears only on reset.
- RAM array is not reset; contents undefined until written.

## Timing

- Reset (`rst=0`, asynchronous): `buf_valid=0`, CYCLE=0, STORES=0, IO_OUT=0, `err=0`. Hence `io_out=0`, `err=0`, `l_data` follows decode (0 unless reading RAM/MMIO).
- Load latency 0 cycles (combinational from `l_addr`, `load_en`, current state).
- Store at edge N: visible to loads in cycle N+1 (via forwarding), in RAM array after edge N+1.
- Reset asserted with `buf_valid=1` discards the buffered store; RAM keeps its last committed contents.
- `err` rises on the edge that samples the faulting request.
- First cycle after reset release: CYCLE reads 0; reads 1 one cycle later.

## Configuration

- `DMEM_MMIO_EN` defined: MMIO window present as above.
- Not defined: no CYCLE/STORES/IO_OUT registers; all `0xFFFF_xxxx` addresses are unmapped (load 0, store dropped, `err` set); `io_out` tied to 0. RAM and store buffer behaviour unchanged.

## Test plan

- Reset, then store `0x0000_0010 <- 0xDEADBEEF`, load same address next cycle -> `l_data=0xDEADBEEF` (forwarded); load again two cycles later -> `0xDEADBEEF` (from array).
- Back-to-back stores `0x0 <- 1`, `0x4 <- 2`, `0x0 <- 3` on consecutive cycles, then loads of 0x0/0x4 -> 3 and 2; STORES reads 3.
- Same cycle: store `0xFFFF_0008 <- 0x55` and load it -> `l_data=0`; next cycle load -> `0x55`, `io_out=0x55`.
- Load `0x0000_0002` (misaligned) -> `l_data=0`, `err=1` after edge and stays 1; store `0x0001_0000` (unmapped, DEPTH=1024) -> dropped, RAM unchanged.
- Release reset, load `0xFFFF_0000` for 5 consecutive cycles -> 0,1,2,3,4; assert `rst=0` mid-clock -> `io_out`, `err`, counters 0 immediately.
- Without `DMEM_MMIO_EN`: load `0xFFFF_0000` -> 0 and `err=1`; store to `0xFFFF_0008` -> `io_out` stays 0.
